// File: rtl/coproc_sequencer_if.sv
// Coprocessor handshake bundle: the sequencer drives the instruction and a start
// strobe, and the coprocessor answers with a one-cycle done pulse.
interface coproc_sequencer_if #(
    parameter int INSTR_W = 22
);
    logic [INSTR_W-1:0] cp_instr;
    logic               cp_start;
    logic               cp_done;

    modport master (output cp_instr, output cp_start, input cp_done);
    modport slave  (input cp_instr, input cp_start, output cp_done);
endinterface

// File: rtl/coproc_sequencer.sv
// Autonomous instruction sequencer for the matrix coprocessor: steps through a small
// program, issuing each instruction with a start strobe and waiting for done.
module coproc_sequencer #(
    parameter int INSTR_W = 22,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                prog_we,
    input  logic [ADDR_W-1:0]   prog_addr,
    input  logic [INSTR_W-1:0]  prog_data,
    input  logic [ADDR_W:0]     prog_len,
    input  logic                run,
    input  logic                step,
    input  logic                abort,
    coproc_sequencer_if.master  cp,
    output logic                busy,
    output logic [ADDR_W-1:0]   pc,
    output logic                done,
    output logic                error
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_FINISH} state_t;

    state_t             r_state;
    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [INSTR_W-1:0] r_rd_data;
    logic [ADDR_W-1:0]  r_pc;
    logic               r_auto;
    logic [TMR_W-1:0]   r_timer;
    logic [INSTR_W-1:0] r_cp_instr;
    logic               r_cp_start;
    logic               r_done;
    logic               r_error;

    logic               w_len_nz;
    logic [ADDR_W:0]    w_pc_ext;
    logic               w_pc_past_len;
    logic               w_last;

    assign w_len_nz      = (prog_len != '0);
    assign w_pc_ext      = {1'b0, r_pc};
    assign w_pc_past_len = (w_pc_ext >= prog_len);
    // ">=" rather than "==" keeps an AUTO run bounded even if prog_len shrinks mid-run
    assign w_last        = ((w_pc_ext + (ADDR_W+1)'(1)) >= prog_len);

    // Program store: contents survive reset; writes only land while idle.
    always_ff @(posedge clk) begin
        if (prog_we && r_state == S_IDLE) begin
            r_mem[prog_addr] <= prog_data;
        end
        r_rd_data <= r_mem[r_pc];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_auto     <= 1'b0;
            r_timer    <= '0;
            r_cp_instr <= '0;
            r_cp_start <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_cp_start <= 1'b0;
            r_done     <= 1'b0;
            if (abort && r_state != S_IDLE) begin
                r_state <= S_IDLE;
                r_pc    <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (run && w_len_nz) begin
                            r_pc    <= '0;
                            r_auto  <= 1'b1;
                            r_error <= 1'b0;
                            r_state <= S_FETCH;
                        end else if (step && w_len_nz) begin
                            if (w_pc_past_len) begin
                                r_pc <= '0;
                            end
                            r_auto  <= 1'b0;
                            r_error <= 1'b0;
                            r_state <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        r_state <= S_ISSUE;
                    end
                    S_ISSUE: begin
                        r_cp_instr <= r_rd_data;
                        r_cp_start <= 1'b1;
                        r_timer    <= '0;
                        r_state    <= S_WAIT;
                    end
                    S_WAIT: begin
                        // done is checked first so it beats a simultaneous timeout
                        if (cp.cp_done) begin
                            if (!r_auto) begin
                                r_pc    <= r_pc + ADDR_W'(1);
                                r_state <= S_IDLE;
                            end else if (w_last) begin
                                r_state <= S_FINISH;
                            end else begin
                                r_pc    <= r_pc + ADDR_W'(1);
                                r_state <= S_FETCH;
                            end
                        end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                            r_error <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_timer <= r_timer + TMR_W'(1);
                        end
                    end
                    S_FINISH: begin
                        r_done  <= 1'b1;
                        r_pc    <= '0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign cp.cp_instr = r_cp_instr;
    assign cp.cp_start = r_cp_start;
    assign busy        = (r_state != S_IDLE);
    assign pc          = r_pc;
    assign done        = r_done;
    assign error       = r_error;
endmodule

// File: tb/tb_coproc_sequencer.sv
// Scoreboard bench for coproc_sequencer: stimulus pushes expected instructions and
// done pulses; a negedge monitor pops and compares what the sequencer actually issues.
module tb_coproc_sequencer;
    localparam int INSTR_W = 22;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic                prog_we;
    logic [ADDR_W-1:0]   prog_addr;
    logic [INSTR_W-1:0]  prog_data;
    logic [ADDR_W:0]     prog_len;
    logic                run, step, abort;
    logic                busy, done, error;
    logic [ADDR_W-1:0]   pc;
    logic                resp_done = 1'b0;
    logic                inj_done;

    coproc_sequencer_if #(.INSTR_W(INSTR_W)) cp_if ();
    assign cp_if.cp_done = resp_done | inj_done;

    coproc_sequencer #(
        .INSTR_W(INSTR_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_len(prog_len), .run(run), .step(step),
        .abort(abort), .cp(cp_if), .busy(busy), .pc(pc), .done(done), .error(error)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: program image, expected pc, expected issue order and done pulses
    logic [INSTR_W-1:0] model_mem [DEPTH];
    int                 model_pc = 0;
    logic [INSTR_W-1:0] exp_q [$];
    int                 exp_done = 0;

    // Coprocessor responder: resp_delay < 0 picks a random latency per instruction
    int silent = 0;
    int resp_delay = 3;
    int resp_cnt = 0;
    int resp_d = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    always @(negedge clk) begin
        resp_done = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) resp_done = 1'b1;
        end
        if (rst_n === 1'b1 && cp_if.cp_start === 1'b1 && silent == 0) begin
            resp_d = (resp_delay < 0) ? int'($urandom_range(0, 8)) : resp_delay;
            if (resp_d == 0) resp_done = 1'b1;
            else resp_cnt = resp_d;
        end
    end

    // Monitor: every issued instruction and done pulse must match the scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (cp_if.cp_start === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL cp_start: got unexpected start instr=0x%0h required none",
                             cp_if.cp_instr);
                end else begin
                    check("cp_instr", 32'(cp_if.cp_instr), 32'(exp_q.pop_front()));
                end
            end
            if (done === 1'b1) begin
                checks++;
                if (exp_done == 0) begin
                    failures++;
                    $display("FAIL done_pulse: got unexpected done required none");
                end else begin
                    exp_done--;
                    $display("ok   done_pulse: pc=%0d busy=%0b", pc, busy);
                end
            end
        end
    end

    task automatic write_entry(input int a, input logic [INSTR_W-1:0] d);
        prog_addr = ADDR_W'(a);
        prog_data = d;
        prog_we = 1'b1;
        @(negedge clk);
        prog_we = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL %s_idle: got busy=%b required 0 within budget", name, busy);
        end
    endtask

    task automatic wait_start(input string name);
        int n;
        n = 0;
        while (cp_if.cp_start !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_start_seen"}, 32'(cp_if.cp_start), 32'd1);
    endtask

    task automatic check_drained(input string name);
        repeat (3) @(negedge clk);
        check({name, "_pending_starts"}, 32'(exp_q.size()), 32'd0);
        check({name, "_pending_done"}, 32'(exp_done), 32'd0);
    endtask

    task automatic do_run(input int len, input string name);
        prog_len = (ADDR_W+1)'(len);
        for (int i = 0; i < len; i++) exp_q.push_back(model_mem[i]);
        exp_done++;
        pulse_run();
        wait_idle(name);
        check_drained(name);
        model_pc = 0;
        check({name, "_pc"}, 32'(pc), 32'(model_pc));
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_error"}, 32'(error), 32'd0);
    endtask

    task automatic do_step(input string name);
        if (model_pc >= int'(prog_len)) model_pc = 0;
        exp_q.push_back(model_mem[model_pc]);
        model_pc++;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        wait_idle(name);
        check({name, "_pc"}, 32'(pc), 32'(model_pc % DEPTH));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int n;
        rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
        run = 1'b0; step = 1'b0; abort = 1'b0; inj_done = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_pc", 32'(pc), 32'd0);
        check("reset_cp_instr", 32'(cp_if.cp_instr), 32'd0);
        check("reset_cp_start", 32'(cp_if.cp_start), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_error", 32'(error), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < DEPTH; i++)
            write_entry(i, (i < 14) ? INSTR_W'(32'h100 + i) : INSTR_W'($urandom));
        resp_delay = 3;
        do_run(14, "full_run");

        resp_delay = -1;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < DEPTH; i++) write_entry(i, INSTR_W'($urandom));
            do_run(int'($urandom_range(1, DEPTH)), "rand_run");
        end

        prog_len = 3;
        for (int s = 0; s < 4; s++) do_step("step");
        check_drained("step");

        prog_len = 4;
        for (int i = 0; i < 4; i++) exp_q.push_back(model_mem[i]);
        exp_done++;
        run = 1'b1; step = 1'b1;
        @(negedge clk);
        run = 1'b0; step = 1'b0;
        wait_idle("run_and_step");
        check_drained("run_and_step");
        model_pc = 0;
        check("run_and_step_pc", 32'(pc), 32'(model_pc));

        silent = 1;
        prog_len = 5;
        exp_q.push_back(model_mem[0]);
        pulse_run();
        wait_start("timeout");
        n = 0;
        while (error !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", 32'(n), 32'(TIMEOUT));
        check("timeout_error", 32'(error), 32'd1);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_pc", 32'(pc), 32'd0);
        check_drained("timeout");
        silent = 0;
        resp_delay = 2;
        do_run(5, "error_clear");

        resp_delay = 6;
        prog_len = 8;
        for (int i = 0; i < 5; i++) exp_q.push_back(model_mem[i]);
        pulse_run();
        cnt = 0;
        for (int k = 0; k < 500; k++) begin
            if (cp_if.cp_start === 1'b1) cnt++;
            if (cnt == 5) break;
            @(negedge clk);
        end
        check("abort_reached_entry4", 32'(cnt), 32'd5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_pc", 32'(pc), 32'd0);
        repeat (20) @(negedge clk);
        check_drained("abort");
        model_pc = 0;

        resp_delay = 3;
        prog_len = 6;
        for (int i = 0; i < 6; i++) exp_q.push_back(model_mem[i]);
        exp_done++;
        pulse_run();
        check("wp_busy", 32'(busy), 32'd1);
        prog_addr = 2;
        prog_data = model_mem[2] ^ 22'h3FFFFF;
        prog_we = 1'b1;
        @(negedge clk);
        prog_we = 1'b0;
        wait_idle("wp_first");
        check_drained("wp_first");
        do_run(6, "wp_rerun");

        resp_delay = 4;
        prog_len = 2;
        exp_q.push_back(model_mem[0]);
        exp_q.push_back(model_mem[1]);
        exp_done++;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        wait_idle("fetch_done");
        check_drained("fetch_done");
        check("fetch_done_pc", 32'(pc), 32'd0);

        prog_len = 0;
        pulse_run();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (3) @(negedge clk);
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_pc", 32'(pc), 32'(model_pc));
        check_drained("len0");

        resp_delay = 8;
        prog_len = 4;
        exp_q.push_back(model_mem[0]);
        pulse_run();
        wait_start("rst_wait");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_wait_pc", 32'(pc), 32'd0);
        check("rst_wait_cp_instr", 32'(cp_if.cp_instr), 32'd0);
        check("rst_wait_cp_start", 32'(cp_if.cp_start), 32'd0);
        check("rst_wait_busy", 32'(busy), 32'd0);
        check("rst_wait_done", 32'(done), 32'd0);
        check("rst_wait_error", 32'(error), 32'd0);
        rst_n = 1'b1;
        model_pc = 0;
        repeat (15) @(negedge clk);
        check("rst_late_done_busy", 32'(busy), 32'd0);
        check_drained("rst_wait");
        resp_delay = 1;
        do_run(4, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
